// File: rtl/bus_pkg.sv
// Shared definitions for the single-initiator system bus: widths, bus direction
// codes, master state encoding and counter operations.
package bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;

  typedef enum logic [1:0] {
    S_FLUSH = 2'd0,
    S_IDLE  = 2'd1,
    S_BUSY  = 2'd2,
    S_TURN  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_CLR  = 2'd1,
    CNT_INC  = 2'd2
  } cnt_op_e;

endpackage

// File: rtl/bus_master_if.sv
// CPU-side handshake and system-bus control lines of the bus master. The
// tristate data lines stay a plain inout on the master itself.
interface bus_master_if;
  import bus_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [BUS_AW-1:0] cpu_addr;
  logic [BUS_DW-1:0] cpu_wdata;
  logic              cpu_busy;
  logic              cpu_done;
  logic              cpu_err;
  logic [BUS_DW-1:0] cpu_rdata;

  logic [BUS_AW-1:0] address;
  logic              request;
  logic              r_w;
  logic              ready;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ready,
    output cpu_busy, cpu_done, cpu_err, cpu_rdata, address, request, r_w
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ready,
    input  cpu_busy, cpu_done, cpu_err, cpu_rdata, address, request, r_w
  );

endinterface

// File: rtl/bus_master.sv
// Single-initiator bus master: turns CPU load/store requests into request/ready
// transactions on the shared tristate bus, with a timeout for unclaimed addresses.
module bus_master
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int FLUSH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  bus_master_if.master     bus,
  inout  wire [BUS_DW-1:0] data
);

  localparam int CNT_TOP = (TIMEOUT > FLUSH) ? TIMEOUT : FLUSH;
  localparam int CNT_W   = $clog2(CNT_TOP) + 1;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] FL_LAST = CNT_W'(FLUSH - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_W'(1);
  endfunction

  state_e            state;
  state_e            state_n;
  cnt_op_e           cnt_op;
  logic [CNT_W-1:0]  cnt;

  logic              load;
  logic              fin_ok;
  logic              fin_err;
  logic              ready_hit;
  logic              drive;

  logic              req_q;
  logic              rw_q;
  logic [BUS_AW-1:0] addr_q;
  logic [BUS_DW-1:0] wdata_q;
  logic              done_q;
  logic              err_q;
  logic [BUS_DW-1:0] rdata_q;

  // Only a solid logic 1 counts; the pulled-down line reads 0 when idle.
  assign ready_hit = (bus.ready == 1'b1);

  always_comb begin
    state_n = state;
    cnt_op  = CNT_HOLD;
    load    = 1'b0;
    fin_ok  = 1'b0;
    fin_err = 1'b0;
    case (state)
      S_FLUSH: begin
        if (cnt == FL_LAST) begin
          state_n = S_IDLE;
          cnt_op  = CNT_CLR;
        end else begin
          cnt_op = CNT_INC;
        end
      end
      S_IDLE: begin
        if (bus.cpu_req) begin
          state_n = S_BUSY;
          load    = 1'b1;
          cnt_op  = CNT_CLR;
        end
      end
      S_BUSY: begin
        // ready has priority over an expiring timeout on the same edge
        if (ready_hit) begin
          fin_ok  = 1'b1;
          state_n = S_TURN;
        end else if (cnt == TO_LAST) begin
          fin_err = 1'b1;
          state_n = S_TURN;
        end else begin
          cnt_op = CNT_INC;
        end
      end
      S_TURN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_FLUSH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FLUSH;
      cnt     <= '0;
      req_q   <= 1'b0;
      rw_q    <= BUS_READ;
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      case (cnt_op)
        CNT_CLR: cnt <= '0;
        CNT_INC: cnt <= sat_inc(cnt);
        default: cnt <= cnt;
      endcase
      done_q <= fin_ok | fin_err;
      err_q  <= fin_err;
      if (load) begin
        addr_q <= bus.cpu_addr;
        rw_q   <= bus.cpu_we;
        req_q  <= 1'b1;
      end else if (fin_ok | fin_err) begin
        req_q <= 1'b0;
        rw_q  <= BUS_READ;
      end
      if (fin_ok && (rw_q == BUS_READ)) begin
        rdata_q <= data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      wdata_q <= bus.cpu_wdata;
    end
  end

  // Tied to state so an asynchronous reset releases the lines at once.
  assign drive = (state == S_BUSY) && (rw_q == BUS_WRITE);
  assign data  = drive ? wdata_q : {BUS_DW{1'bz}};

  assign bus.address   = addr_q;
  assign bus.request   = req_q;
  assign bus.r_w       = rw_q;
  assign bus.cpu_busy  = (state != S_IDLE);
  assign bus.cpu_done  = done_q;
  assign bus.cpu_err   = err_q;
  assign bus.cpu_rdata = rdata_q;

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: two four-wait-state memory slaves on the bus, a
// transaction-level reference model and directed load/store scenarios.
module tb_bus_master;
  import bus_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int FLUSH   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init = 1'b1;
  always #5 clk = ~clk;

  bus_master_if bif();
  wire [31:0] data;

  bus_master #(.TIMEOUT(TIMEOUT), .FLUSH(FLUSH)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bif),
    .data (data)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h cyc=%0d", nm, act, req, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%b want=%b cyc=%0d", nm, act, req, cyc);
    end
  endtask

  task automatic chki(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d cyc=%0d", nm, act, req, cyc);
    end
  endtask

  // Two memory slaves: 0x00-0x1F and 0x20-0x3F. Once started a slave finishes
  // its access even if request drops, then waits for request low.
  logic [31:0] smem   [2][32];
  logic        s_busy [2];
  logic        s_srv  [2];
  logic        s_we   [2];
  logic        s_rdy  [2];
  logic        s_oe   [2];
  logic [2:0]  s_cnt  [2];
  logic [4:0]  s_idx  [2];
  logic [31:0] s_dout [2];

  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (init) begin
        for (int i = 0; i < 32; i++) smem[s][i] <= 32'hA000_0000 | 32'(s * 32 + i);
        s_busy[s] <= 1'b0;
        s_srv[s]  <= 1'b0;
        s_we[s]   <= 1'b0;
        s_rdy[s]  <= 1'b0;
        s_oe[s]   <= 1'b0;
        s_cnt[s]  <= 3'd0;
        s_idx[s]  <= 5'd0;
        s_dout[s] <= 32'd0;
      end else begin
        s_rdy[s] <= 1'b0;
        s_oe[s]  <= 1'b0;
        if (s_busy[s]) begin
          if (s_cnt[s] == 3'd3) begin
            s_rdy[s]  <= 1'b1;
            s_busy[s] <= 1'b0;
            s_srv[s]  <= 1'b1;
            if (s_we[s]) smem[s][s_idx[s]] <= data;
            else begin
              s_oe[s]   <= 1'b1;
              s_dout[s] <= smem[s][s_idx[s]];
            end
          end else begin
            s_cnt[s] <= s_cnt[s] + 3'd1;
          end
        end else if (s_srv[s]) begin
          if (!bif.request) s_srv[s] <= 1'b0;
        end else if (bif.request && (bif.address[31:5] == 27'(s))) begin
          s_busy[s] <= 1'b1;
          s_cnt[s]  <= 3'd1;
          s_we[s]   <= bif.r_w;
          s_idx[s]  <= bif.address[4:0];
        end
      end
    end
  end

  assign bif.ready = s_rdy[0] | s_rdy[1];
  assign data = s_oe[0] ? s_dout[0] : (s_oe[1] ? s_dout[1] : 32'bz);

  // Reference model: a transaction accepted at edge n completes at n+5 (mapped)
  // or n+TIMEOUT+1 (unmapped); the next accept is possible two edges later.
  logic [31:0] mmem [64];
  bit          m_act = 1'b0;
  int          m_done_at = 0;
  int          m_avail = 0;
  logic        m_we = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_wd = 32'd0;
  logic        e_done = 1'b0;
  logic        e_err = 1'b0;
  logic        e_req = 1'b0;
  logic        e_rw = 1'b0;
  logic        e_busy = 1'b1;
  logic [31:0] e_rdata = 32'd0;
  logic [31:0] e_addr = 32'd0;

  initial begin
    for (int i = 0; i < 64; i++) mmem[i] = 32'hA000_0000 | 32'(i);
    forever begin
      @(posedge clk);
      cyc++;
      e_done = 1'b0;
      e_err  = 1'b0;
      if (rst) begin
        m_act   = 1'b0;
        m_avail = cyc + FLUSH + 1;
        e_rdata = 32'd0;
        e_addr  = 32'd0;
      end else if (m_act) begin
        if (cyc == m_done_at) begin
          m_act   = 1'b0;
          e_done  = 1'b1;
          m_avail = cyc + 2;
          if (m_addr < 32'h40) begin
            if (m_we) mmem[m_addr[5:0]] = m_wd;
            else e_rdata = mmem[m_addr[5:0]];
          end else begin
            e_err = 1'b1;
          end
        end
      end else if (cyc >= m_avail && bif.cpu_req) begin
        m_act     = 1'b1;
        m_we      = bif.cpu_we;
        m_addr    = bif.cpu_addr;
        m_wd      = bif.cpu_wdata;
        e_addr    = bif.cpu_addr;
        m_done_at = cyc + ((bif.cpu_addr < 32'h40) ? 5 : TIMEOUT + 1);
      end
      e_req  = m_act;
      e_rw   = m_act && m_we;
      e_busy = m_act || (cyc < m_avail - 1);
    end
  end

  // Cycle-by-cycle comparison, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        if (rst) begin
          chk1("rst_request", bif.request, 1'b0);
          chk1("rst_r_w", bif.r_w, 1'b0);
          chk1("rst_done", bif.cpu_done, 1'b0);
          chk1("rst_err", bif.cpu_err, 1'b0);
          chk1("rst_busy", bif.cpu_busy, 1'b1);
          chk32("rst_address", bif.address, 32'd0);
          chk32("rst_rdata", bif.cpu_rdata, 32'd0);
        end else begin
          chk1("done", bif.cpu_done, e_done);
          chk1("err", bif.cpu_err, e_err);
          chk1("request", bif.request, e_req);
          chk1("busy", bif.cpu_busy, e_busy);
          chk32("rdata", bif.cpu_rdata, e_rdata);
          if (e_req) begin
            chk32("address", bif.address, e_addr);
            chk1("r_w", bif.r_w, e_rw);
            if (e_rw) chk32("wdata_bus", data, m_wd);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         output int rise, output int dn, output logic err,
                         output logic [31:0] rd);
    rise = -1;
    dn   = -1;
    err  = 1'b0;
    rd   = 32'd0;
    bif.cpu_req   = 1'b1;
    bif.cpu_we    = we;
    bif.cpu_addr  = a;
    bif.cpu_wdata = wd;
    for (int i = 0; i < 60 && rise < 0; i++) begin
      tick();
      if (bif.request) rise = cyc;
    end
    bif.cpu_req = 1'b0;
    if (rise >= 0) begin
      for (int i = 0; i < 60 && dn < 0; i++) begin
        tick();
        if (bif.cpu_done) begin
          dn  = cyc;
          err = bif.cpu_err;
          rd  = bif.cpu_rdata;
        end
      end
    end
    total++;
    if (dn < 0) begin
      bad++;
      $display("FAIL txn_complete addr=%h got rise=%0d done=%0d want a completion", a, rise, dn);
    end
    tick();
    tick();
  endtask

  int          rise, dn, rel, nacc, ndone, lowcnt;
  int          dedge [3];
  logic        err, prev;
  logic [31:0] rd;

  initial begin
    bif.cpu_req   = 1'b0;
    bif.cpu_we    = 1'b0;
    bif.cpu_addr  = 32'd0;
    bif.cpu_wdata = 32'd0;
    repeat (3) tick();
    init = 1'b0;
    chk1("reset_request", bif.request, 1'b0);
    chk1("reset_busy", bif.cpu_busy, 1'b1);
    chk32("reset_rdata", bif.cpu_rdata, 32'd0);
    rst = 1'b0;
    rel = cyc;

    run_txn(1'b1, 32'h05, 32'hDEAD_BEEF, rise, dn, err, rd);
    chk1("flush_holdoff", (rise - rel) > FLUSH, 1'b1);
    chki("wr_latency", dn - rise, 5);
    chk1("wr_err", err, 1'b0);

    run_txn(1'b0, 32'h05, 32'h0, rise, dn, err, rd);
    chki("rd_latency", dn - rise, 5);
    chk1("rd_err", err, 1'b0);
    chk32("rd_05", rd, 32'hDEAD_BEEF);

    run_txn(1'b1, 32'h25, 32'h1234_5678, rise, dn, err, rd);
    chk1("wr25_err", err, 1'b0);
    run_txn(1'b0, 32'h25, 32'h0, rise, dn, err, rd);
    chk32("rd_25", rd, 32'h1234_5678);
    run_txn(1'b0, 32'h05, 32'h0, rise, dn, err, rd);
    chk32("rd_05_again", rd, 32'hDEAD_BEEF);

    run_txn(1'b0, 32'h100, 32'h0, rise, dn, err, rd);
    chki("timeout_latency", dn - rise, 17);
    chk1("timeout_err", err, 1'b1);
    chk32("timeout_rdata", rd, 32'hDEAD_BEEF);
    chk1("timeout_req_low", bif.request, 1'b0);

    // Back-to-back reads with cpu_req held high
    nacc = 0;
    ndone = 0;
    lowcnt = 0;
    prev = 1'b0;
    bif.cpu_we   = 1'b0;
    bif.cpu_addr = 32'h10;
    bif.cpu_req  = 1'b1;
    for (int i = 0; i < 80 && ndone < 3; i++) begin
      tick();
      if (bif.request && !prev) begin
        nacc++;
        bif.cpu_addr = 32'h10 + 32'(nacc);
        if (nacc == 3) bif.cpu_req = 1'b0;
      end
      prev = bif.request;
      if (ndone > 0 && !bif.request) lowcnt++;
      if (bif.cpu_done) begin
        dedge[ndone] = cyc;
        ndone++;
      end
    end
    bif.cpu_req = 1'b0;
    chki("b2b_dones", ndone, 3);
    if (ndone == 3) begin
      chki("b2b_gap1", dedge[1] - dedge[0], 7);
      chki("b2b_gap2", dedge[2] - dedge[1], 7);
    end
    chk1("b2b_req_gaps", lowcnt >= 2, 1'b1);
    chk32("b2b_last_rdata", bif.cpu_rdata, 32'hA000_0012);
    tick();
    tick();

    // Reset two cycles into a read, then an immediate new read
    bif.cpu_we   = 1'b0;
    bif.cpu_addr = 32'h05;
    bif.cpu_req  = 1'b1;
    rise = -1;
    for (int i = 0; i < 20 && rise < 0; i++) begin
      tick();
      if (bif.request) rise = cyc;
    end
    chk1("rst_txn_started", rise >= 0, 1'b1);
    bif.cpu_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk1("async_req_drop", bif.request, 1'b0);
    chk1("async_busy", bif.cpu_busy, 1'b1);
    tick();
    rst = 1'b0;
    rel = cyc;
    run_txn(1'b0, 32'h06, 32'h0, rise, dn, err, rd);
    chk1("reflush_holdoff", (rise - rel) > FLUSH, 1'b1);
    chki("rd06_latency", dn - rise, 5);
    chk1("rd06_err", err, 1'b0);
    chk32("rd_06", rd, 32'hA000_0006);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
